// File: rtl/alu_calc_pkg.sv
// ---------------------------------------------------------------------------
// alu_calc_pkg
//   Shared definitions for the switch/button ALU calculator:
//   - opcode encodings for the sel[2:0] field (OP_ADD .. OP_SHR)
//   - SEG_BLANK, the active-low pattern that turns every segment off
//   - hex_to_seg(), a 4-bit hex to active-low {g,f,e,d,c,b,a} font lookup
// ---------------------------------------------------------------------------
package alu_calc_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_SHR = 3'd7;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    case (hex)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_scan.sv
// ---------------------------------------------------------------------------
// seg7_scan
//   Time-multiplexed driver for a 4-digit common-anode 7-segment display.
//   A free-running SCAN_BITS counter selects the digit via its two MSBs:
//     digit0 = y[3:0], digit1 = y[7:4], digit2 = blank, digit3 = {0,sel}.
//   seg and an are both registered so they always change on the same edge.
// Ports
//   clk   in   system clock
//   rst   in   asynchronous active-high reset (seg blank, all anodes off)
//   y     in   8-bit value shown on digits 1..0 in hex
//   sel   in   3-bit opcode shown on digit 3
//   seg   out  segments {g,f,e,d,c,b,a}, active low
//   an    out  digit anodes, active low, an[0] = rightmost
// ---------------------------------------------------------------------------
module seg7_scan
  import alu_calc_pkg::*;
#(
  parameter int SCAN_BITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] y,
  input  logic [2:0] sel,
  output logic [6:0] seg,
  output logic [3:0] an
);

  logic [SCAN_BITS-1:0] scan_cnt;
  logic [1:0]           digit;
  logic [6:0]           seg_next;
  logic [3:0]           an_next;

  assign digit = scan_cnt[SCAN_BITS-1 -: 2];

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned, which would infer a latch.
    seg_next = SEG_BLANK;
    an_next  = 4'b1111;
    case (digit)
      2'd0: begin
        seg_next = hex_to_seg(y[3:0]);
        an_next  = 4'b1110;
      end
      2'd1: begin
        seg_next = hex_to_seg(y[7:4]);
        an_next  = 4'b1101;
      end
      2'd2: begin
        seg_next = SEG_BLANK;
        an_next  = 4'b1011;
      end
      default: begin
        seg_next = hex_to_seg({1'b0, sel});
        an_next  = 4'b0111;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      seg      <= SEG_BLANK;
      an       <= 4'b1111;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
      seg      <= seg_next;
      an       <= an_next;
    end
  end

endmodule

// File: rtl/alu_calculator.sv
// ---------------------------------------------------------------------------
// alu_calculator
//   Board-level 8-bit two-operand calculator.
//   btn1 loads operand A from the switches, btn2 loads operand B. Each button
//   goes through a 2-FF synchronizer and a debouncer that requires DB_CYCLES
//   consecutive high samples; the rising edge of the debounced level gives a
//   single one-cycle load pulse, so a held button loads exactly once.
//   sel picks one of eight ALU ops; the result is registered on Y every cycle
//   and shown on the multiplexed 7-segment display together with sel.
// Ports
//   clk   in   system clock, all state on rising edge
//   rst   in   asynchronous active-high reset
//   btn1  in   load-A pushbutton, active high, asynchronous
//   btn2  in   load-B pushbutton, active high, asynchronous
//   in    in   8-bit operand switches
//   sel   in   3-bit operation select
//   Y     out  registered 8-bit ALU result
//   seg   out  segments {g,f,e,d,c,b,a}, active low
//   an    out  digit anodes, active low, an[0] = rightmost
// ---------------------------------------------------------------------------
module alu_calculator
  import alu_calc_pkg::*;
#(
  parameter int DB_CYCLES = 4,
  parameter int SCAN_BITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn1,
  input  logic       btn2,
  input  logic [7:0] in,
  input  logic [2:0] sel,
  output logic [7:0] Y,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam int DB_W = $clog2(DB_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_FULL = DB_W'(DB_CYCLES);

  logic [1:0] btn_raw;
  logic [1:0] load_pulse;   // [0] = load A, [1] = load B
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [7:0] alu_result;

  assign btn_raw = {btn2, btn1};

  // Button conditioning: identical logic for both buttons.
  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic            sync_meta;
    logic            sync_out;
    logic [DB_W-1:0] stable_cnt;
    logic            level_q;
    logic            level;

    // The count saturates at DB_FULL; any low sample restarts it, which is
    // what rejects glitches shorter than DB_CYCLES.
    assign level         = (stable_cnt == DB_FULL);
    assign load_pulse[i] = level & ~level_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_meta  <= 1'b0;
        sync_out   <= 1'b0;
        stable_cnt <= '0;
        level_q    <= 1'b0;
      end else begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values; with blocking assignments the
        // two synchronizer stages would collapse into one.
        sync_meta <= btn_raw[i];
        sync_out  <= sync_meta;
        level_q   <= level;
        if (!sync_out) begin
          stable_cnt <= '0;
        end else if (stable_cnt != DB_FULL) begin
          stable_cnt <= stable_cnt + 1'b1;
        end
      end
    end
  end

  // Operand registers; both may load the same switch value in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a <= '0;
      op_b <= '0;
    end else begin
      if (load_pulse[0]) op_a <= in;
      if (load_pulse[1]) op_b <= in;
    end
  end

  // 8-bit ALU; carries and borrows fall off the top (mod 256).
  always_comb begin
    alu_result = '0;
    case (sel)
      OP_ADD:  alu_result = op_a + op_b;
      OP_SUB:  alu_result = op_a - op_b;
      OP_AND:  alu_result = op_a & op_b;
      OP_OR:   alu_result = op_a | op_b;
      OP_XOR:  alu_result = op_a ^ op_b;
      OP_NOT:  alu_result = ~op_a;
      OP_SHL:  alu_result = {op_a[6:0], 1'b0};
      default: alu_result = {1'b0, op_a[7:1]};
    endcase
  end

  // Y follows the ALU one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y <= '0;
    end else begin
      Y <= alu_result;
    end
  end

  seg7_scan #(
    .SCAN_BITS (SCAN_BITS)
  ) u_scan (
    .clk (clk),
    .rst (rst),
    .y   (Y),
    .sel (sel),
    .seg (seg),
    .an  (an)
  );

endmodule

// File: tb/tb_alu_calculator.sv
// ---------------------------------------------------------------------------
// tb_alu_calculator
//   Directed-vector bench for alu_calculator with a scoreboard: the stimulus
//   process pushes hand-computed expectations into queues and raises a
//   strobe; independent monitor processes pop and compare against the DUT.
// ---------------------------------------------------------------------------
module tb_alu_calculator;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn1;
  logic       btn2;
  logic [7:0] in_sw;
  logic [2:0] sel;
  logic [7:0] y;
  logic [6:0] seg;
  logic [3:0] an;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [7:0] y;
  } y_exp_t;

  typedef struct {
    string      name;
    logic [3:0] an;
    logic [6:0] seg;
  } scan_exp_t;

  y_exp_t    y_q[$];
  scan_exp_t scan_q[$];
  logic      y_strobe = 1'b0;

  alu_calculator #(
    .DB_CYCLES (4),
    .SCAN_BITS (4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .btn1 (btn1),
    .btn2 (btn2),
    .in   (in_sw),
    .sel  (sel),
    .Y    (y),
    .seg  (seg),
    .an   (an)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Y monitor: compares one queued expectation per strobe.
  always @(negedge clk) begin
    if (y_strobe) begin
      if (y_q.size() == 0) begin
        check("y_queue_empty", 32'(y_q.size()), 32'd1);
      end else begin
        y_exp_t e;
        e = y_q.pop_front();
        check(e.name, {24'd0, y}, {24'd0, e.y});
      end
    end
  end

  // Scan monitor: compares {an,seg} each time the active digit changes.
  logic [3:0] an_prev = 4'hF;
  always @(negedge clk) begin
    if (an !== an_prev && scan_q.size() != 0) begin
      scan_exp_t s;
      s = scan_q.pop_front();
      check({s.name, "_an"},  {28'd0, an},  {28'd0, s.an});
      check({s.name, "_seg"}, {25'd0, seg}, {25'd0, s.seg});
    end
    an_prev = an;
  end

  task automatic expect_y(input string name, input logic [7:0] val);
    y_exp_t e;
    e.name = name;
    e.y    = val;
    y_q.push_back(e);
    @(posedge clk);
    y_strobe = 1'b1;
    @(posedge clk);
    y_strobe = 1'b0;
  endtask

  // Drive the switches, hold the selected buttons, release, and let it settle.
  task automatic press(input logic [1:0] mask, input logic [7:0] val, input int hold);
    @(negedge clk);
    in_sw = val;
    btn1  = mask[0];
    btn2  = mask[1];
    repeat (hold) @(negedge clk);
    btn1 = 1'b0;
    btn2 = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic set_sel(input logic [2:0] s);
    @(negedge clk);
    sel = s;
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_an(input logic [3:0] target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (an === target) ok = 1'b1;
    end
  endtask

  task automatic wait_scan_drain(input string name);
    for (int i = 0; i < 100 && scan_q.size() != 0; i++) @(negedge clk);
    check(name, 32'(scan_q.size()), 32'd0);
  endtask

  task automatic push_scan(input string name, input logic [3:0] a, input logic [6:0] s);
    scan_exp_t e;
    e.name = name;
    e.an   = a;
    e.seg  = s;
    scan_q.push_back(e);
  endtask

  initial begin
    bit ok;
    rst   = 1'b1;
    btn1  = 1'b0;
    btn2  = 1'b0;
    in_sw = 8'h00;
    sel   = 3'd0;

    // 1: reset state
    repeat (2) @(negedge clk);
    check("rst_y",   {24'd0, y},   32'h00);
    check("rst_seg", {25'd0, seg}, 32'h7F);
    check("rst_an",  {28'd0, an},  32'hF);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("an_onehot", 32'($countones(~an)), 32'd1);
    expect_y("reset_ab_zero", 8'h00);
    wait_an(4'b1011, ok);
    check("wait_digit2", {31'd0, ok}, 32'd1);
    @(posedge clk);
    push_scan("digit3_zero", 4'b0111, 7'b1000000);
    wait_scan_drain("digit3_drain");

    // 2: load operands
    press(2'b01, 8'h51, 10);
    press(2'b10, 8'h06, 10);
    set_sel(3'd0);
    expect_y("add_51_06", 8'h57);

    // 3: op sweep with A=51, B=06
    set_sel(3'd1); expect_y("sub", 8'h4B);
    set_sel(3'd2); expect_y("and", 8'h00);
    set_sel(3'd3); expect_y("or",  8'h57);
    set_sel(3'd4); expect_y("xor", 8'h57);
    set_sel(3'd5); expect_y("not", 8'hAE);
    set_sel(3'd6); expect_y("shl", 8'hA2);
    set_sel(3'd7); expect_y("shr", 8'h28);
    set_sel(3'd0); expect_y("add_again", 8'h57);

    // 4: wrap-around
    press(2'b01, 8'hFF, 10);
    press(2'b10, 8'h02, 10);
    expect_y("add_wrap", 8'h01);
    press(2'b01, 8'h00, 10);
    press(2'b10, 8'h01, 10);
    set_sel(3'd1);
    expect_y("sub_wrap", 8'hFF);

    // 5: short glitch ignored, long hold loads once
    set_sel(3'd0);
    press(2'b01, 8'h33, 3);
    expect_y("glitch_ignored", 8'h01);
    @(negedge clk);
    in_sw = 8'h3C;
    btn1  = 1'b1;
    repeat (15) @(negedge clk);
    in_sw = 8'h99;
    repeat (35) @(negedge clk);
    btn1 = 1'b0;
    repeat (4) @(negedge clk);
    expect_y("hold_single_load", 8'h3D);
    press(2'b11, 8'h10, 10);
    expect_y("both_same_cycle", 8'h20);

    // 6: scan walk with Y=A2, sel=6
    press(2'b01, 8'h51, 10);
    set_sel(3'd6);
    expect_y("scan_y", 8'hA2);
    wait_an(4'b0111, ok);
    check("wait_digit3", {31'd0, ok}, 32'd1);
    @(posedge clk);
    push_scan("scan_d0", 4'b1110, 7'b0100100);
    push_scan("scan_d1", 4'b1101, 7'b0001000);
    push_scan("scan_d2", 4'b1011, 7'b1111111);
    push_scan("scan_d3", 4'b0111, 7'b0000010);
    wait_scan_drain("scan_drain");

    check("y_queue_drain", 32'(y_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
